// File: rtl/psum_accumulator.sv
// Per-column partial-sum accumulator: sums row psums across K tiles with
// signed saturation, then drains the results over a valid/ready handshake.
module psum_accumulator #(
   parameter int PSUM_W = 40,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int TILE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic [ADDR_W:0]   num_rows,
   input  logic              psum_valid,
   input  logic [PSUM_W-1:0] psum_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PSUM_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN
   } state_e;

   localparam logic [PSUM_W-1:0] SMAX = {1'b0, {(PSUM_W-1){1'b1}}};
   localparam logic [PSUM_W-1:0] SMIN = {1'b1, {(PSUM_W-1){1'b0}}};
   localparam logic [ADDR_W:0]   ROWS_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_R = (ADDR_W+1)'(1);
   localparam logic [TILE_W-1:0] ONE_T = TILE_W'(1);

   state_e state_q, state_d;

   logic [TILE_W-1:0] tiles_q, tiles_d;
   logic [ADDR_W:0]   rows_q, rows_d;
   logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [PSUM_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;

   logic [PSUM_W-1:0] mem_q [DEPTH];

   logic              wr_en;
   logic [PSUM_W-1:0] wr_data;
   logic [PSUM_W-1:0] rd_acc;
   logic [PSUM_W:0]   sum;
   logic              sat_hit;
   logic [PSUM_W-1:0] sat_val;
   logic [PSUM_W-1:0] acc_val;
   logic              row_last;
   logic              tile_last;
   logic [ADDR_W-1:0] nxt_ptr;
   logic [TILE_W-1:0] tiles_eff;
   logic [ADDR_W:0]   rows_eff;

   always_comb begin
      tiles_eff = (num_tiles == '0) ? ONE_T : num_tiles;
      rows_eff  = num_rows;
      if (num_rows == '0 || num_rows > ROWS_MAX) begin
         rows_eff = ROWS_MAX;
      end
   end

   // Sum in PSUM_W+1 bits; top two bits disagree exactly on overflow.
   always_comb begin
      rd_acc  = mem_q[row_cnt_q];
      sum     = {psum_i[PSUM_W-1], psum_i} + {rd_acc[PSUM_W-1], rd_acc};
      sat_hit = sum[PSUM_W] ^ sum[PSUM_W-1];
      sat_val = sum[PSUM_W-1:0];
      if (sat_hit) begin
         sat_val = sum[PSUM_W] ? SMIN : SMAX;
      end
      acc_val = (tile_cnt_q == '0) ? psum_i : sat_val;
   end

   always_comb begin
      row_last  = ({1'b0, row_cnt_q} == rows_q - ONE_R);
      tile_last = (tile_cnt_q == tiles_q - ONE_T);
      nxt_ptr   = rd_ptr_q + ADDR_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      tiles_d     = tiles_q;
      rows_d      = rows_q;
      tile_cnt_d  = tile_cnt_q;
      row_cnt_d   = row_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      overflow_d  = overflow_q;
      wr_en       = 1'b0;
      wr_data     = acc_val;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               tiles_d    = tiles_eff;
               rows_d     = rows_eff;
               overflow_d = 1'b0;
               tile_cnt_d = '0;
               row_cnt_d  = '0;
               state_d    = S_ACCUM;
            end
         end

         S_ACCUM: begin
            if (psum_valid) begin
               wr_en = 1'b1;
               if (tile_cnt_q != '0 && sat_hit) begin
                  overflow_d = 1'b1;
               end
               if (row_last) begin
                  row_cnt_d  = '0;
                  tile_cnt_d = tile_cnt_q + ONE_T;
                  if (tile_last) begin
                     // Row 0 may be the one being written right now.
                     state_d     = S_DRAIN;
                     tile_cnt_d  = '0;
                     rd_ptr_d    = '0;
                     out_valid_d = 1'b1;
                     out_last_d  = (rows_q == ONE_R);
                     out_data_d  = (row_cnt_q == '0) ? acc_val : mem_q[0];
                  end
               end else begin
                  row_cnt_d = row_cnt_q + ADDR_W'(1);
               end
            end
         end

         S_DRAIN: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  rd_ptr_d    = '0;
               end else begin
                  rd_ptr_d   = nxt_ptr;
                  out_data_d = mem_q[nxt_ptr];
                  out_last_d = ({1'b0, nxt_ptr} == rows_q - ONE_R);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         tiles_q     <= '0;
         rows_q      <= '0;
         tile_cnt_q  <= '0;
         row_cnt_q   <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tiles_q     <= tiles_d;
         rows_q      <= rows_d;
         tile_cnt_q  <= tile_cnt_d;
         row_cnt_q   <= row_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
      end
   end

   // Buffer holds no reset value; tile 0 always overwrites it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[row_cnt_q] <= wr_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised bench for psum_accumulator with a queue-based reference model
// of tile accumulation, saturation and drain ordering.
module tb_psum_accumulator;

   localparam longint MAXV = 64'sd549755813887;
   localparam longint MINV = -64'sd549755813888;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  num_tiles;
   logic [4:0]  num_rows;
   logic        psum_valid;
   logic [39:0] psum_i;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        overflow;

   int n_chk = 0;
   int n_err = 0;
   longint pq[$];

   psum_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_tiles (num_tiles),
      .num_rows  (num_rows),
      .psum_valid(psum_valid),
      .psum_i    (psum_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_rand(int n);
      longint v;
      logic [39:0] r;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 4))
            0, 1: v = longint'($urandom_range(0, 2000)) - 1000;
            2: v = MAXV - longint'($urandom_range(0, 1000));
            3: v = MINV + longint'($urandom_range(0, 1000));
            default: begin
               r = {$urandom, $urandom};
               v = $signed(r);
            end
         endcase
         pq.push_back(v);
      end
   endtask

   task automatic run_job(string nm, int tiles_in, int rows_in,
                          int rmode, bit bub);
      int te, re, idx, cyc, pi;
      longint acc[16];
      longint s, v;
      logic [39:0] e40;
      logic [39:0] prev;
      bit ovf, stalled, rdy, first;
      int pat[5] = '{0, 1, 0, 0, 1};

      te = (tiles_in == 0) ? 1 : tiles_in;
      re = (rows_in == 0 || rows_in > 16) ? 16 : rows_in;
      ovf = 1'b0;
      for (int t = 0; t < te; t++) begin
         for (int r = 0; r < re; r++) begin
            v = pq[t*re + r];
            if (t == 0) begin
               acc[r] = v;
            end else begin
               s = acc[r] + v;
               if (s > MAXV) begin
                  s = MAXV;
                  ovf = 1'b1;
               end else if (s < MINV) begin
                  s = MINV;
                  ovf = 1'b1;
               end
               acc[r] = s;
            end
         end
      end

      start = 1'b1;
      num_tiles = tiles_in[7:0];
      num_rows = rows_in[4:0];
      @(negedge clk);
      start = 1'b0;
      check({nm, ".busy"}, 64'(busy), 64'(1));
      check({nm, ".ovf_clr"}, 64'(overflow), 64'(0));

      for (int i = 0; i < te*re; i++) begin
         if (bub) begin
            repeat ($urandom_range(0, 2)) begin
               psum_valid = 1'b0;
               psum_i = 40'($urandom);
               @(negedge clk);
            end
         end
         psum_valid = 1'b1;
         v = pq[i];
         psum_i = v[39:0];
         @(negedge clk);
         if (i != te*re - 1 && !out_valid) n_chk++;
         else if (i != te*re - 1) check({nm, ".early_valid"}, 64'(out_valid), 64'(0));
      end
      psum_valid = 1'b0;

      idx = 0;
      cyc = 0;
      pi = 0;
      first = 1'b1;
      stalled = 1'b0;
      prev = '0;
      while (idx < re && cyc < 400) begin
         if (first) check({nm, ".lat"}, 64'(out_valid), 64'(1));
         first = 1'b0;
         if (out_valid) begin
            e40 = acc[idx][39:0];
            check({nm, ".data"}, 64'(out_data), 64'(e40));
            check({nm, ".last"}, 64'(out_last), 64'(idx == re - 1));
            if (stalled) check({nm, ".hold"}, 64'(out_data), 64'(prev));
         end
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 2) != 0);
            default: rdy = pat[pi % 5][0];
         endcase
         pi++;
         out_ready = rdy;
         if (rmode != 0 && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            num_tiles = 8'($urandom);
            num_rows = 5'($urandom);
         end else begin
            start = 1'b0;
         end
         psum_valid = 1'($urandom);
         psum_i = 40'($urandom);
         stalled = out_valid && !rdy;
         prev = out_data;
         if (out_valid && rdy) idx++;
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 400) check({nm, ".drain_timeout"}, 64'(1), 64'(0));
      start = 1'b0;
      psum_valid = 1'b0;
      out_ready = 1'b0;
      check({nm, ".done"}, 64'(done), 64'(1));
      check({nm, ".busy_end"}, 64'(busy), 64'(0));
      check({nm, ".vld_end"}, 64'(out_valid), 64'(0));
      check({nm, ".ovf"}, 64'(overflow), 64'(ovf));
      @(negedge clk);
      check({nm, ".done_1cyc"}, 64'(done), 64'(0));
      pq.delete();
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      num_tiles = '0;
      num_rows = '0;
      psum_valid = 1'b0;
      psum_i = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.valid", 64'(out_valid), 64'(0));
      check("rst.done", 64'(done), 64'(0));
      check("rst.ovf", 64'(overflow), 64'(0));
      check("rst.data", 64'(out_data), 64'(0));
      check("rst.last", 64'(out_last), 64'(0));
      rst = 1'b1;
      @(negedge clk);

      repeat (3) begin
         psum_valid = 1'b1;
         psum_i = 40'($urandom);
         @(negedge clk);
         check("idle.busy", 64'(busy), 64'(0));
      end
      psum_valid = 1'b0;

      pq = '{5, -2, 7};
      run_job("single", 1, 3, 0, 0);

      pq = '{1, 2, 10, 20, 100, 200};
      run_job("multi", 3, 2, 0, 1);
      pq = '{1, 2, 10, 20, 100, 200};
      run_job("bp", 3, 2, 2, 1);

      pq = '{MAXV, 5};
      run_job("sat_pos", 2, 1, 0, 0);
      pq = '{MINV, -1};
      run_job("sat_neg", 2, 1, 0, 0);

      start = 1'b1;
      num_tiles = 8'd1;
      num_rows = 5'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (2) begin
         psum_valid = 1'b1;
         psum_i = 40'($urandom);
         @(negedge clk);
      end
      psum_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst.busy", 64'(busy), 64'(0));
      check("mid_rst.valid", 64'(out_valid), 64'(0));
      check("mid_rst.done", 64'(done), 64'(0));
      repeat (4) begin
         @(negedge clk);
         check("mid_rst.quiet", 64'({done, out_valid, busy}), 64'(0));
      end

      pq = '{3, 4, 5, 6};
      run_job("after_rst", 1, 4, 1, 1);

      fill_rand(16);
      run_job("rows0", 0, 0, 1, 1);
      fill_rand(32);
      run_job("rows20", 2, 20, 1, 0);

      for (int j = 0; j < 20; j++) begin
         int t, r;
         t = $urandom_range(1, 4);
         r = $urandom_range(1, 16);
         fill_rand(t * r);
         run_job("rand", t, r, 1, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
